// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/mem_arb_resp_tracker.sv
// Tracks the single in-flight memory transaction: latency count, owner, rvalid pulse and
// per-requester read-data capture.
module mem_arb_resp_tracker
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_owner,
  input  logic              start_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  localparam int unsigned CntW = $clog2(LAT + 1);

  arb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              done;
  logic              d_load_done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    done        = (state_q == StBusy) && (cnt_q == CntW'(LAT)) && !reset;
    if_rvalid   = done && (owner_q == OWN_IF);
    d_rvalid    = done && (owner_q == OWN_D);
    d_load_done = d_rvalid && !we_q;
    busy        = (state_q == StBusy);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          owner_d = start_owner;
          we_d    = start_we;
          cnt_d   = CntW'(1);
        end
      end
      StBusy: begin
        if (cnt_q == CntW'(LAT)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (if_rvalid)   if_rdata_d = mem_rdata;
    if (d_load_done) d_rdata_d  = mem_rdata;

    // Data is passed straight through in the rvalid cycle, then held.
    if_rdata = if_rvalid   ? mem_rdata : if_rdata_q;
    d_rdata  = d_load_done ? mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch (IF) and data (D) requesters.
// Optional grant statistics are enabled with the MEM_ARB_STATS_EN macro.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_if_cnt,
  output logic [STAT_W-1:0] stat_d_cnt
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          busy;
  logic          if_starved;

  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    starve_d   = starve_q;
    if_starved = (starve_q == SW'(STARVE_MAX));

    if (!busy && !reset) begin
      if (d_req && !(if_req && if_starved)) begin
        d_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        if (!if_req)         starve_d = '0;
        else if (!if_starved) starve_d = starve_q + 1'b1;
      end else if (if_req) begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = if_addr;
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  mem_arb_resp_tracker #(
    .DATA_W (DATA_W),
    .LAT    (LAT)
  ) u_resp_tracker (
    .clk         (clk),
    .reset       (reset),
    .start       (if_gnt | d_gnt),
    .start_owner (d_gnt ? OWN_D : OWN_IF),
    .start_we    (d_gnt & d_we),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata)
  );

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_if_q, stat_if_d;
  logic [STAT_W-1:0] stat_d_q, stat_d_d;

  always_comb begin
    stat_if_d = stat_if_q;
    stat_d_d  = stat_d_q;
    if (if_gnt && (stat_if_q != '1)) stat_if_d = stat_if_q + 1'b1;
    if (d_gnt && (stat_d_q != '1))   stat_d_d  = stat_d_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_if_q <= '0;
      stat_d_q  <= '0;
    end else begin
      stat_if_q <= stat_if_d;
      stat_d_q  <= stat_d_d;
    end
  end

  assign stat_if_cnt = stat_if_q;
  assign stat_d_cnt  = stat_d_q;
`else
  assign stat_if_cnt = '0;
  assign stat_d_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=1 instance with a memory model, LAT=3 instance
// for the mid-transaction reset case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int exp_if   = 0;
  int exp_d    = 0;

  // Main instance, LAT=1
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] stat_if_cnt, stat_d_cnt;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stat_if_cnt(stat_if_cnt), .stat_d_cnt(stat_d_cnt)
  );

  // Memory model: unwritten word at address a reads as a+2; one-cycle read latency.
  logic [31:0] mem_q [256];
  logic        wr_v  [256];
  logic [31:0] rdata_q;
  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) wr_v[i] <= 1'b0;
      rdata_q <= '0;
    end else if (mem_en) begin
      rdata_q <= wr_v[mem_addr] ? mem_q[mem_addr] : {24'b0, mem_addr} + 32'd2;
      if (mem_we) begin
        mem_q[mem_addr] <= mem_wdata;
        wr_v[mem_addr]  <= 1'b1;
      end
    end
  end

  // Second instance, LAT=3, constant read data
  logic        rst3;
  logic        if_req3, d_req3, d_we3;
  logic [7:0]  if_addr3, d_addr3;
  logic [31:0] d_wdata3;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [7:0]  mem_addr3;
  logic [15:0] stat_if_cnt3, stat_d_cnt3;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(rst3),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
    .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_gnt(d_gnt3),
    .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .stat_if_cnt(stat_if_cnt3), .stat_d_cnt(stat_d_cnt3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        if_req;
    logic [7:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_if_rv;
    logic        e_d_rv;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs[6];

  // Expected arbitration order with both requests held and STARVE_MAX=4
  logic pat[15];
  int   n_g;

  initial begin
    vecs[0] = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 32'h0,
                1'b1, 1'b0, 1'b0, 8'h03, 32'h0, 1'b1, 1'b0, 32'h5, 32'h0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 32'h0,
                1'b0, 1'b1, 1'b0, 8'h08, 32'h0, 1'b0, 1'b1, 32'h5, 32'hA};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0F, 32'hDEAD_BEEF,
                1'b0, 1'b1, 1'b1, 8'h0F, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h5, 32'hA};
    vecs[3] = '{1'b1, 8'h0F, 1'b0, 1'b0, 8'h00, 32'h0,
                1'b1, 1'b0, 1'b0, 8'h0F, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hA};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 32'h0,
                1'b0, 1'b1, 1'b0, 8'hFF, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h101};
    vecs[5] = '{1'b1, 8'h08, 1'b0, 1'b1, 8'h33, 32'h1234,
                1'b1, 1'b0, 1'b0, 8'h08, 32'h0, 1'b1, 1'b0, 32'hA, 32'h101};
    for (int i = 0; i < 15; i++) pat[i] = ((i % 5) == 4);  // 1 = IF grant

    mem_rdata3 = 32'hCAFE_0001;
    reset = 1'b1; rst3 = 1'b1;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; if_addr = 8'h11; d_addr = 8'h22;
    d_wdata = 32'h5555;
    if_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0; if_addr3 = '0; d_addr3 = '0;
    d_wdata3 = '0;

    // Reset: requests asserted, yet nothing is granted
    step();
    @(negedge clk);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    step();
    reset = 1'b0; rst3 = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Single-requester table
    for (int i = 0; i < 6; i++) begin
      step();
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), if_gnt, vecs[i].e_if_gnt);
      chk($sformatf("v%0d_d_gnt", i), d_gnt, vecs[i].e_d_gnt);
      chk($sformatf("v%0d_mem_en", i), mem_en, 1);
      chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      if (vecs[i].e_if_gnt) exp_if++;
      if (vecs[i].e_d_gnt) exp_d++;
      step();
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_busy_gnt", i), if_gnt | d_gnt, 0);
      chk($sformatf("v%0d_if_rvalid", i), if_rvalid, vecs[i].e_if_rv);
      chk($sformatf("v%0d_d_rvalid", i), d_rvalid, vecs[i].e_d_rv);
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_d_rdata);
    end

    // Both request: D first, IF two cycles later
    step();
    if_req = 1'b1; if_addr = 8'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h08;
    @(negedge clk);
    chk("both_d_gnt", d_gnt, 1);
    chk("both_if_gnt0", if_gnt, 0);
    exp_d++;
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("both_d_rvalid", d_rvalid, 1);
    chk("both_d_rdata", d_rdata, 32'hA);
    chk("both_if_gnt1", if_gnt, 0);
    chk("both_if_rvalid_nonowner", if_rvalid, 0);
    step();
    @(negedge clk);
    chk("both_if_gnt2", if_gnt, 1);
    chk("both_if_addr", mem_addr, 8'h20);
    exp_if++;
    step();
    if_req = 1'b0;
    @(negedge clk);
    chk("both_if_rvalid", if_rvalid, 1);
    chk("both_if_rdata", if_rdata, 32'h22);
    chk("both_d_rvalid_nonowner", d_rvalid, 0);

    // Starvation guard: both held continuously
    step();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01; if_addr = 8'h02;
    n_g = 0;
    for (int cyc = 0; cyc < 60 && n_g < 15; cyc++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) chk("starve_dual_gnt", 1, 0);
      if (if_gnt || d_gnt) begin
        chk($sformatf("starve_g%0d_is_if", n_g), if_gnt, pat[n_g]);
        if (pat[n_g]) exp_if++;
        else exp_d++;
        n_g++;
      end
      step();
      if (n_g == 15) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    chk("starve_grant_count", n_g, 15);
    if_req = 1'b0; d_req = 1'b0;
    step();

`ifdef MEM_ARB_STATS_EN
    chk("stat_if_cnt", stat_if_cnt, exp_if);
    chk("stat_d_cnt", stat_d_cnt, exp_d);
`else
    chk("stat_if_cnt_off", stat_if_cnt, 0);
    chk("stat_d_cnt_off", stat_d_cnt, 0);
`endif

    // LAT=3: normal IF fetch, rvalid three cycles after grant
    step();
    if_req3 = 1'b1; if_addr3 = 8'h44;
    @(negedge clk);
    chk("l3_if_gnt", if_gnt3, 1);
    step();
    if_req3 = 1'b0;
    @(negedge clk);
    chk("l3_rv_t1", if_rvalid3, 0);
    step();
    @(negedge clk);
    chk("l3_rv_t2", if_rvalid3, 0);
    step();
    @(negedge clk);
    chk("l3_rv_t3", if_rvalid3, 1);
    chk("l3_rdata_t3", if_rdata3, 32'hCAFE_0001);

    // LAT=3: reset in the first BUSY cycle abandons the load
    step();
    d_req3 = 1'b1; d_addr3 = 8'h55;
    @(negedge clk);
    chk("l3_d_gnt", d_gnt3, 1);
    step();
    d_req3 = 1'b0; rst3 = 1'b1;
    @(negedge clk);
    chk("l3_rst_d_rvalid", d_rvalid3, 0);
    chk("l3_rst_mem_en", mem_en3, 0);
    step();
    rst3 = 1'b0; if_req3 = 1'b1; if_addr3 = 8'h66;
    @(negedge clk);
    chk("l3_post_rst_if_gnt", if_gnt3, 1);
    chk("l3_post_rst_if_rdata", if_rdata3, 0);
    chk("l3_post_rst_d_rdata", d_rdata3, 0);
    chk("l3_post_rst_d_rvalid", d_rvalid3, 0);
    step();
    if_req3 = 1'b0;
    @(negedge clk);
    chk("l3_abandoned_slot_d_rvalid", d_rvalid3, 0);
    chk("l3_abandoned_slot_if_rvalid", if_rvalid3, 0);
    step();
    @(negedge clk);
    chk("l3_new_rv_t2", if_rvalid3, 0);
    step();
    @(negedge clk);
    chk("l3_new_rv_t3", if_rvalid3, 1);
    chk("l3_new_d_rvalid", d_rvalid3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port unified memory between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the fetch/PC logic and load/store unit on one side, and the memory array on the other, inside cpu_top.
- Supports one outstanding transaction at a time with fixed memory read latency.
- Data side has priority; a starvation guard guarantees fetch forward progress.

Parameters:
- ADDR_W, 8, memory word address width
- DATA_W, 32, memory data width
- LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid LAT cycles after mem_en
- STARVE_MAX, 4, consecutive D grants allowed while IF is waiting before IF is forced

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch command accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data command accepted
- d_rvalid  out  1  load data valid / store completion ack
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stat_if_cnt  out  16  IF grant count (optional feature)
- stat_d_cnt  out  16  D grant count (optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values:
  - state=IDLE, owner=none, latency counter=0, starve counter=0.
  - All gnt/rvalid/mem_en/mem_we outputs are 0; addr/wdata/rdata outputs are 0.
- FSM states:
  - IDLE: gnt and mem_* are combinational from req and arbitration. On any grant, go to BUSY, latch owner and we, set cnt=1.
  - BUSY: no grants. cnt increments each cycle. When cnt==LAT, assert the owner's rvalid for exactly 1 cycle and go to IDLE on the next edge.
- Timing:
  - Grant at cycle t; rvalid at cycle t+LAT.
  - Next grant is possible at t+LAT+1, so peak throughput is 1 transaction per LAT+1 cycles.
- Arbitration in IDLE:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both requesting: grant D unless starve==STARVE_MAX, in which case grant IF.
- Starve counter:
  - +1 on each D grant while if_req=1, saturating at STARVE_MAX.
  - Cleared on an IF grant, or on a D grant with if_req=0.
- Memory command (granted cycle only):
  - mem_en=1.
  - mem_we = d_we for D, 0 for IF.
  - mem_addr and mem_wdata are taken from the winner.
  - mem_wdata=0 for IF.
- Read data:
  - rdata = mem_rdata in the rvalid cycle; held at last value otherwise.
  - For a store, d_rvalid still pulses at t+LAT as the completion ack; d_rdata is unchanged.
- Non-owner response outputs stay 0 while the other requester's transaction is in flight.
- Requests arriving while BUSY wait; requesters must not drop req before gnt (protocol violation, undefined).
- Reset asserted mid-BUSY: transaction abandoned, no rvalid pulse; IDLE on the next edge.
- No address range checking; the address wraps naturally at 2^ADDR_W.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - stat_if_cnt and stat_d_cnt increment on each respective grant.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops are generated.

Decomposition:
- Package mem_arb_pkg:
  - State encoding (IDLE=1'b0, BUSY=1'b1).
  - Owner ID constants (OWN_IF=1'b0, OWN_D=1'b1).
  - Stats counter width constant (16).
- Sub-module mem_arb_resp_tracker:
  - Holds the latency counter and latched owner.
  - Generates the per-owner rvalid pulse and rdata capture.
  - The top level keeps arbitration and the starve counter.

Test Plan:
- Reset, then IF-only fetch (if_addr=8'h03, memory[3]=32'h0000_0005, LAT=1):
  - Expect if_gnt at t, mem_en=1, mem_addr=8'h03.
  - Expect if_rvalid at t+1 with if_rdata=32'h5.
- Simultaneous if_req and d_req load (d_addr=8'h08):
  - Expect d_gnt first; if_gnt 2 cycles later.
  - Expect d_rdata equal to memory[8].
- Store (d_we=1, d_addr=8'h0F, d_wdata=32'hDEAD_BEEF):
  - Expect mem_we=1 in the grant cycle and d_rvalid ack at t+1.
  - A subsequent IF read of 8'h0F returns 32'hDEAD_BEEF.
- Starvation: d_req and if_req held high continuously with STARVE_MAX=4:
  - Expect exactly 4 consecutive d_gnt, then 1 if_gnt, then the pattern repeats.
- Reset asserted in the BUSY cycle (LAT=3, after grant):
  - Expect no rvalid pulse, all outputs 0.
  - A new grant is possible on the cycle after reset deasserts.
- With MEM_ARB_STATS_EN, 3 IF + 5 D transactions: expect stat_if_cnt=3, stat_d_cnt=5; without the macro, both read 0.
